// File: rtl/booth_result_accumulator.sv
// Block accumulator behind the 8x8 Booth multiplier: sums acc_len signed products
// into a saturating ACC_W-bit accumulator and presents each block sum via valid/ready.
module booth_result_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic [CNT_W-1:0]  acc_len,
  input  logic [PROD_W-1:0] product,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              overflow,
  output logic [CNT_W-1:0]  count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_r, state_s;
  logic [ACC_W-1:0]   acc_r, acc_s;
  logic [CNT_W-1:0]   count_r, count_s;
  logic [CNT_W-1:0]   target_r, target_s;
  logic               ovf_r, ovf_s;
  logic               valid_r, valid_s;
  logic [CNT_W-1:0]   len_s;
  logic [CNT_W-1:0]   count_inc_s;
  logic [ACC_W-1:0]   prod_ext_s;
  logic [ACC_W:0]     sat_sum_s;
  logic               prod_xfer_s;
  logic               res_xfer_s;

  // Bit ACC_W of the return value flags a clamp; the low ACC_W bits are the clamped sum.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                             input logic [PROD_W-1:0] p);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){p[PROD_W-1]}}, p};
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W]) begin
        sat_add = {1'b1, 1'b1, {(ACC_W-1){1'b0}}};
      end else begin
        sat_add = {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
      end
    end else begin
      sat_add = {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  assign prod_ready   = RST & (state_r != OUT);
  assign prod_xfer_s  = prod_valid & prod_ready;
  assign res_xfer_s   = valid_r & result_ready;
  assign len_s        = (acc_len == CNT_ZERO) ? CNT_ONE : acc_len;
  assign count_inc_s  = count_r + CNT_ONE;
  assign prod_ext_s   = {{(ACC_W-PROD_W){product[PROD_W-1]}}, product};
  assign sat_sum_s    = sat_add(acc_r, product);

  assign result       = acc_r;
  assign result_valid = valid_r;
  assign overflow     = ovf_r;
  assign count        = count_r;

  // Next-state and datapath update; clear overrides every state.
  always_comb begin
    state_s  = state_r;
    acc_s    = acc_r;
    count_s  = count_r;
    target_s = target_r;
    ovf_s    = ovf_r;
    valid_s  = valid_r;
    if (clear) begin
      state_s = IDLE;
      acc_s   = {ACC_W{1'b0}};
      count_s = CNT_ZERO;
      ovf_s   = 1'b0;
      valid_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (prod_xfer_s) begin
            acc_s    = prod_ext_s;
            count_s  = CNT_ONE;
            target_s = len_s;
            ovf_s    = 1'b0;
            if (len_s == CNT_ONE) begin
              state_s = OUT;
              valid_s = 1'b1;
            end else begin
              state_s = ACC;
            end
          end else begin
            state_s = IDLE;
          end
        end
        ACC: begin
          if (prod_xfer_s) begin
            acc_s   = sat_sum_s[ACC_W-1:0];
            ovf_s   = ovf_r | sat_sum_s[ACC_W];
            count_s = count_inc_s;
            if (count_inc_s == target_r) begin
              state_s = OUT;
              valid_s = 1'b1;
            end else begin
              state_s = ACC;
            end
          end else begin
            state_s = ACC;
          end
        end
        OUT: begin
          if (res_xfer_s) begin
            state_s = IDLE;
            valid_s = 1'b0;
            count_s = CNT_ZERO;
          end else begin
            state_s = OUT;
          end
        end
        default: begin
          state_s = IDLE;
          acc_s   = {ACC_W{1'b0}};
          count_s = CNT_ZERO;
          ovf_s   = 1'b0;
          valid_s = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r  <= IDLE;
      acc_r    <= {ACC_W{1'b0}};
      count_r  <= CNT_ZERO;
      target_r <= CNT_ZERO;
      ovf_r    <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      acc_r    <= acc_s;
      count_r  <= count_s;
      target_r <= target_s;
      ovf_r    <= ovf_s;
      valid_r  <= valid_s;
    end
  end

endmodule

// File: tb/tb_booth_result_accumulator.sv
// Directed bench for booth_result_accumulator: a 24-bit and an 18-bit instance share
// stimulus and are checked every cycle against a block-sum model plus literal values.
module tb_booth_result_accumulator;

  logic        CLK;
  logic        RST;
  logic        clear;
  logic [3:0]  acc_len;
  logic [15:0] product;
  logic        prod_valid;
  logic        result_ready;

  logic        pr24, rv24, ov24;
  logic [23:0] r24;
  logic [3:0]  c24;
  logic        pr18, rv18, ov18;
  logic [17:0] r18;
  logic [3:0]  c18;

  int errors = 0;
  int checks = 0;

  booth_result_accumulator dut24 (
    .CLK(CLK), .RST(RST), .clear(clear), .acc_len(acc_len), .product(product),
    .prod_valid(prod_valid), .prod_ready(pr24), .result(r24), .result_valid(rv24),
    .result_ready(result_ready), .overflow(ov24), .count(c24)
  );

  booth_result_accumulator #(.ACC_W(18)) dut18 (
    .CLK(CLK), .RST(RST), .clear(clear), .acc_len(acc_len), .product(product),
    .prod_valid(prod_valid), .prod_ready(pr18), .result(r18), .result_valid(rv18),
    .result_ready(result_ready), .overflow(ov18), .count(c18)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Model: index 0 is the 24-bit instance, index 1 the 18-bit instance.
  int     wid[2]    = '{24, 18};
  longint m_sum[2]  = '{0, 0};
  int     m_n[2]    = '{0, 0};
  int     m_len[2]  = '{0, 0};
  bit     m_ovf[2]  = '{1'b0, 1'b0};
  bit     m_pres[2] = '{1'b0, 1'b0};

  function automatic longint clampv(input longint v, input int w);
    longint lim;
    lim = longint'(1) <<< (w - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim) return -lim;
    return v;
  endfunction

  always @(posedge CLK or negedge RST) begin
    for (int k = 0; k < 2; k++) begin
      if (!RST || clear) begin
        m_sum[k] <= 0; m_n[k] <= 0; m_ovf[k] <= 1'b0; m_pres[k] <= 1'b0;
      end else if (m_pres[k]) begin
        if (result_ready) begin
          m_pres[k] <= 1'b0;
          m_n[k]    <= 0;
        end
      end else if (prod_valid) begin
        if (m_n[k] == 0) begin
          m_sum[k]  <= longint'($signed(product));
          m_len[k]  <= (acc_len == 4'd0) ? 1 : int'(acc_len);
          m_n[k]    <= 1;
          m_ovf[k]  <= 1'b0;
          m_pres[k] <= (acc_len <= 4'd1);
        end else begin
          m_sum[k] <= clampv(m_sum[k] + longint'($signed(product)), wid[k]);
          if (clampv(m_sum[k] + longint'($signed(product)), wid[k]) !=
              m_sum[k] + longint'($signed(product)))
            m_ovf[k] <= 1'b1;
          m_n[k] <= m_n[k] + 1;
          if (m_n[k] + 1 == m_len[k]) m_pres[k] <= 1'b1;
        end
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge CLK) begin
    if (RST) begin
      check("prod_ready24", longint'(pr24), longint'(!m_pres[0]));
      check("result_valid24", longint'(rv24), longint'(m_pres[0]));
      check("count24", longint'(c24), longint'(m_n[0]));
      check("overflow24", longint'(ov24), longint'(m_ovf[0]));
      if (m_pres[0]) check("result24", longint'($signed(r24)), m_sum[0]);
      check("prod_ready18", longint'(pr18), longint'(!m_pres[1]));
      check("result_valid18", longint'(rv18), longint'(m_pres[1]));
      check("count18", longint'(c18), longint'(m_n[1]));
      check("overflow18", longint'(ov18), longint'(m_ovf[1]));
      if (m_pres[1]) check("result18", longint'($signed(r18)), m_sum[1]);
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic put(input logic [15:0] p);
    product    = p;
    prod_valid = 1'b1;
    cyc();
    prod_valid = 1'b0;
  endtask

  task automatic take();
    result_ready = 1'b1;
    cyc();
    result_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_prod_ready"}, longint'(pr24 | pr18), 0);
    check({tag, "_result_valid"}, longint'(rv24 | rv18), 0);
    check({tag, "_overflow"}, longint'(ov24 | ov18), 0);
    check({tag, "_count"}, longint'(c24 | c18), 0);
    check({tag, "_result"}, longint'(r24), 0);
    check({tag, "_result18"}, longint'(r18), 0);
  endtask

  initial begin
    RST = 1'b0; clear = 1'b0; acc_len = 4'd0; product = 16'h0000;
    prod_valid = 1'b0; result_ready = 1'b0;
    #1;
    check_all_zero("por");
    cyc(); cyc();
    RST = 1'b1;
    #1;
    check("ready_after_reset", longint'(pr24), 1);
    cyc();

    // Two-product block: -4522 + 1846 = -2676.
    acc_len = 4'd2;
    put(16'hEE56);
    put(16'h0736);
    check("two_valid", longint'(rv24), 1);
    check("two_result24", longint'(r24), longint'(24'hFFF58C));
    check("two_result18", longint'(r18), longint'(18'h3F58C));
    check("two_count", longint'(c24), 2);
    check("two_ovf", longint'(ov24), 0);
    take();
    check("two_after_take", longint'(rv24), 0);

    // Length 0 behaves as length 1.
    acc_len = 4'd0;
    put(16'h0CEA);
    check("len0_valid", longint'(rv24), 1);
    check("len0_result", longint'(r24), longint'(24'h000CEA));
    take();

    // Back-pressure: result held, extra products refused.
    acc_len = 4'd3;
    put(16'h0A1E); put(16'h0A1E); put(16'h0A1E);
    product = 16'h7FFF; prod_valid = 1'b1;
    repeat (5) cyc();
    check("bp_result", longint'(r24), longint'(24'h001E5A));
    check("bp_ready", longint'(pr24), 0);
    check("bp_count", longint'(c24), 3);
    product = 16'h0100; acc_len = 4'd1; result_ready = 1'b1;
    cyc();
    check("bp_released", longint'(rv24), 0);
    cyc();
    prod_valid = 1'b0;
    check("bp_next_valid", longint'(rv24), 1);
    check("bp_next_result", longint'(r24), longint'(24'h000100));
    cyc();
    result_ready = 1'b0;

    // Saturation on the 18-bit instance: 8 x 16384 exceeds 131071.
    acc_len = 4'd9;
    repeat (7) put(16'h4000);
    check("sat_ovf7", longint'(ov18), 0);
    put(16'h4000);
    check("sat_ovf8", longint'(ov18), 1);
    put(16'h4000);
    check("sat_result18", longint'(r18), longint'(18'h1FFFF));
    check("sat_ovf18", longint'(ov18), 1);
    check("sat_result24", longint'(r24), longint'(24'h024000));
    check("sat_ovf24", longint'(ov24), 0);
    check("sat_count", longint'(c18), 9);
    take();
    acc_len = 4'd1;
    put(16'h0001);
    check("sat_next_ovf", longint'(ov18), 0);
    check("sat_next_result", longint'(r18), 1);
    take();

    // clear mid-block drops partial sum and the concurrent product.
    acc_len = 4'd4;
    put(16'h0100); put(16'h0100);
    product = 16'h1234; prod_valid = 1'b1; clear = 1'b1;
    cyc();
    clear = 1'b0; prod_valid = 1'b0;
    check("clr_count", longint'(c24), 0);
    check("clr_ready", longint'(pr24), 1);
    acc_len = 4'd1;
    put(16'h0005);
    check("clr_next_result", longint'(r24), 5);
    // clear beats a result transfer.
    result_ready = 1'b1; clear = 1'b1;
    cyc();
    clear = 1'b0; result_ready = 1'b0;
    check("clr_out_valid", longint'(rv24), 0);
    check("clr_out_count", longint'(c24), 0);
    cyc();

    // Asynchronous reset mid-accumulation.
    acc_len = 4'd5;
    put(16'h0010); put(16'h0010); put(16'h0010);
    check("rst_pre_count", longint'(c24), 3);
    RST = 1'b0;
    #2;
    check_all_zero("midrst");
    cyc();
    RST = 1'b1;
    #1;
    check("rst_ready", longint'(pr24), 1);
    check("rst_count", longint'(c24), 0);
    acc_len = 4'd1;
    put(16'h0007);
    check("rst_next_result", longint'(r24), 7);
    take();
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
